// File: rtl/spram_fifo_ctrl.sv
// FIFO controller for a single-port synchronous RAM. One RAM access per cycle is arbitrated
// between push and pop; a 2-entry prefetch buffer hides the RAM read latency.
module spram_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned RamCntWidth = $clog2(FIFO_DEPTH + 1);
    localparam logic [RamCntWidth-1:0] RamFull = RamCntWidth'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  PtrMax  = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]   CntFull = CNT_WIDTH'(FIFO_DEPTH + 2);

    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [RamCntWidth-1:0] ram_cnt_q, ram_cnt_d;
    logic [1:0]             obuf_cnt_q, obuf_cnt_d;
    logic                   obuf_head_q, obuf_head_d;
    logic                   rd_inflight_q, rd_inflight_d;
    logic                   wr_pri_q, wr_pri_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]  obuf_q [2];

    logic ram_space;
    logic ram_has;
    logic obuf_room;
    logic rd_req;
    logic wr_req;
    logic conflict;
    logic wr_gnt;
    logic rd_gnt;
    logic pop;
    logic capture;
    logic obuf_tail;

    // Request, arbitration and handshake decode
    always_comb begin
        ram_space = ram_cnt_q < RamFull;
        ram_has   = ram_cnt_q != '0;
        obuf_room = ({1'b0, obuf_cnt_q} + {2'b00, rd_inflight_q}) < 3'd2;
        rd_req    = rst_n && ram_has && obuf_room;
        wr_req    = rst_n && in_valid && ram_space;
        conflict  = rd_req && wr_req;
        wr_gnt    = wr_req && (!rd_req || wr_pri_q);
        rd_gnt    = rd_req && !(wr_req && wr_pri_q);
        // Independent of in_valid: ready is promised before the pusher commits.
        in_ready  = rst_n && ram_space && !(rd_req && !wr_pri_q);
        out_valid = rst_n && (obuf_cnt_q != 2'd0);
        pop       = out_valid && out_ready;
        capture   = rst_n && rd_inflight_q;
        // Capture never sees a full obuf, so the tail is head + cnt modulo 2.
        obuf_tail = obuf_head_q ^ obuf_cnt_q[0];
    end

    always_comb begin
        ram_we   = wr_gnt;
        ram_din  = in_data;
        ram_addr = '0;
        if (rst_n) begin
            ram_addr = wr_gnt ? wr_ptr_q : rd_ptr_q;
        end
        out_data = obuf_q[obuf_head_q];
        count    = count_q;
        empty    = count_q == '0;
        full     = count_q == CntFull;
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ram_cnt_d     = ram_cnt_q;
        wr_pri_d      = wr_pri_q;
        rd_inflight_d = rd_gnt;
        if (wr_gnt) begin
            wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_gnt) begin
            rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
        end
        ram_cnt_d   = ram_cnt_q + {{(RamCntWidth-1){1'b0}}, wr_gnt}
                                - {{(RamCntWidth-1){1'b0}}, rd_gnt};
        if (conflict) begin
            wr_pri_d = !wr_pri_q;
        end
        obuf_cnt_d  = obuf_cnt_q + {1'b0, capture} - {1'b0, pop};
        obuf_head_d = obuf_head_q ^ pop;
        count_d     = count_q + {{(CNT_WIDTH-1){1'b0}}, wr_gnt}
                              - {{(CNT_WIDTH-1){1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            obuf_cnt_q    <= 2'd0;
            obuf_head_q   <= 1'b0;
            rd_inflight_q <= 1'b0;
            wr_pri_q      <= 1'b0;
            count_q       <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            obuf_cnt_q    <= obuf_cnt_d;
            obuf_head_q   <= obuf_head_d;
            rd_inflight_q <= rd_inflight_d;
            wr_pri_q      <= wr_pri_d;
            count_q       <= count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by obuf_cnt.
    always_ff @(posedge clk) begin
        if (capture) begin
            obuf_q[obuf_tail] <= ram_dout;
        end
    end

    logic [CNT_WIDTH-1:0] held_sum;
    assign held_sum = CNT_WIDTH'(ram_cnt_q) + CNT_WIDTH'(obuf_cnt_q) + CNT_WIDTH'(rd_inflight_q);

    held_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        count_q == held_sum);
    capture_has_room: assert property (@(posedge clk) disable iff (!rst_n)
        rd_inflight_q |-> (obuf_cnt_q != 2'd2));

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Self-checking bench for spram_fifo_ctrl: RAM model, queue-based reference model,
// directed scenarios and randomized traffic.
module tb_spram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 5;
    localparam int CAP   = DEPTH + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    always #5 clk = ~clk;

    spram_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    // Single-port synchronous RAM, one-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: ordered queue of held values plus total accepted writes.
    logic [DW-1:0] ref_q [$];
    int unsigned   wr_total;
    int            stall;

    logic          s_push, s_pop, s_we, s_ovalid, s_iready, s_empty, s_full;
    logic [DW-1:0] s_odata;
    logic [AW-1:0] s_addr;
    logic [CW-1:0] s_count;

    task automatic cycle();
        @(negedge clk);
        s_push   = in_valid && in_ready;
        s_pop    = out_valid && out_ready;
        s_we     = ram_we;
        s_addr   = ram_addr;
        s_ovalid = out_valid;
        s_iready = in_ready;
        s_odata  = out_data;
        s_empty  = empty;
        s_full   = full;
        s_count  = count;
        if (rst_n !== 1'b1) begin
            ref_q.delete();
            wr_total = 0;
            stall    = 0;
        end else begin
            check_eq("count", count, ref_q.size());
            check_eq("empty", empty, ref_q.size() == 0);
            check_eq("full", full, ref_q.size() == CAP);
            check_eq("ram_we", ram_we, s_push);
            check_eq("ram_din", ram_din, in_data);
            if (s_push) check_eq("wr_addr", ram_addr, wr_total % DEPTH);
            if (ref_q.size() == CAP) check_eq("in_ready_at_cap", in_ready, 0);
            if (out_valid) begin
                if (ref_q.size() == 0) check_eq("spurious_out", out_valid, 0);
                else check_eq("out_data", out_data, ref_q[0]);
            end
            if (ref_q.size() > 0 && !out_valid) stall++;
            else stall = 0;
            if (stall == 7) check_eq("head_latency", out_valid, 1);
            if (s_pop && ref_q.size() > 0) void'(ref_q.pop_front());
            if (s_push) begin
                ref_q.push_back(in_data);
                wr_total++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input bit chk);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (chk) begin
                check_eq("rst_in_ready", s_iready, 0);
                check_eq("rst_out_valid", s_ovalid, 0);
                check_eq("rst_ram_we", s_we, 0);
                if (i > 0) begin
                    check_eq("rst_empty", s_empty, 1);
                    check_eq("rst_count", s_count, 0);
                    check_eq("rst_ram_addr", s_addr, 0);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  v, e, cyc, maxc, same, ok;
        bit  prev_we, saw_ready;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // 1: reset hold with in_valid asserted
        in_valid = 1'b1;
        in_data  = 8'h11;
        do_reset(3, 1'b1);
        cycle();
        check_eq("t1_first_push", s_push, 1);
        in_valid = 1'b0;

        // 2: single-beat latency
        do_reset(2, 1'b0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        cycle();
        check_eq("t2_we_T", s_we, 1);
        check_eq("t2_addr_T", s_addr, 0);
        in_valid = 1'b0;
        cycle();
        check_eq("t2_we_T1", s_we, 0);
        check_eq("t2_rdaddr_T1", s_addr, 0);
        check_eq("t2_valid_T1", s_ovalid, 0);
        cycle();
        check_eq("t2_valid_T2", s_ovalid, 0);
        cycle();
        check_eq("t2_valid_T3", s_ovalid, 1);
        check_eq("t2_data_T3", s_odata, 8'hA5);
        cycle();
        check_eq("t2_empty_after", s_empty, 1);

        // 3: fill to full
        do_reset(2, 1'b0);
        out_ready = 1'b0;
        v = 0;
        for (int i = 0; i < 60; i++) begin
            in_valid = (v < 20);
            in_data  = DW'(v);
            cycle();
            if (s_push) v++;
        end
        check_eq("t3_accepted", v, 18);
        cycle();
        check_eq("t3_count", s_count, 18);
        check_eq("t3_full", s_full, 1);
        check_eq("t3_in_ready", s_iready, 0);
        check_eq("t3_head", s_odata, 0);

        // 4: drain after fill
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e         = 0;
        saw_ready = 1'b0;
        for (int i = 0; i < 100 && e < 18; i++) begin
            cycle();
            if (i == 0) check_eq("t4_ready_first", s_iready, 0);
            if (s_iready) saw_ready = 1'b1;
            if (s_pop) begin
                check_eq("t4_order", s_odata, e);
                e++;
            end
        end
        check_eq("t4_pops", e, 18);
        cycle();
        check_eq("t4_empty", s_empty, 1);
        check_eq("t4_ready_back", saw_ready, 1);

        // 5: sustained push+pop contention
        do_reset(2, 1'b0);
        out_ready = 1'b1;
        v = 0; e = 0; maxc = 0; same = 0; cyc = 0; prev_we = 1'b0;
        while (cyc < 200 && e < 40) begin
            in_valid = (v < 40);
            in_data  = DW'(v);
            cycle();
            if (int'(s_count) > maxc) maxc = int'(s_count);
            // Once steady, write and read grants strictly alternate.
            if (cyc >= 8 && cyc <= 70 && s_we == prev_we) same++;
            prev_we = s_we;
            if (s_push) v++;
            if (s_pop) begin
                check_eq("t5_order", s_odata, DW'(e));
                e++;
            end
            cyc++;
        end
        check_eq("t5_pops", e, 40);
        check_eq("t5_alternation_breaks", same, 0);
        check_eq("t5_low_occupancy", maxc <= 4, 1);
        check_eq("t5_half_rate", cyc <= 90, 1);

        // 6: reset with data held and a read in flight
        do_reset(2, 1'b0);
        out_ready = 1'b0;
        v = 0;
        for (int i = 0; i < 60 && v < 11; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(8'h50 + v);
            cycle();
            if (s_push) v++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        out_ready = 1'b1;
        cycle();
        check_eq("t6_pop", s_pop, 1);
        out_ready = 1'b0;
        cycle();
        check_eq("t6_count_held", s_count, 10);
        check_eq("t6_rd_issue_we", s_we, 0);
        check_eq("t6_rd_issue_addr", s_addr, 2);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        check_eq("t6_valid_after_rst", s_ovalid, 0);
        check_eq("t6_count_after_rst", s_count, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("t6_no_stale", s_ovalid, 0);
        end
        in_valid = 1'b1;
        in_data  = 8'h3C;
        cycle();
        in_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 10 && ok == 0; i++) begin
            cycle();
            if (s_ovalid) begin
                check_eq("t6_new_data", s_odata, 8'h3C);
                ok = 1;
            end
        end
        check_eq("t6_new_beat_seen", ok, 1);

        // Randomized traffic against the reference model
        do_reset(2, 1'b0);
        for (int blk = 0; blk < 6; blk++) begin
            int pv, pr;
            pv = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            for (int i = 0; i < 250; i++) begin
                in_valid  = ($urandom_range(0, 99) < pv);
                in_data   = DW'($urandom);
                out_ready = ($urandom_range(0, 99) < pr);
                cycle();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && ref_q.size() > 0; i++) cycle();
        cycle();
        check_eq("rand_drained", s_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
